// File: rtl/osnt_packet_sampler_pkg.sv
// osnt_packet_sampler_pkg
//   Shared definitions for the 1-in-N packet sampler: FSM state encodings,
//   TUSER length-field offsets, sample-index width and the sample-index
//   helper functions used by the top-level decision logic.
package osnt_packet_sampler_pkg;

  // Packet-level FSM: waiting for a head beat, forwarding, or discarding.
  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // OSNT metadata carries the packet byte length in tuser[15:0].
  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_LEN_MSB = 15;

  localparam int IDX_WIDTH = 32;

  // An index left out of range by a smaller ratio restarts the cycle at 0,
  // so the head that sees it is treated as the first of a fresh group.
  function automatic logic [IDX_WIDTH-1:0] idx_effective(
    input logic [IDX_WIDTH-1:0] idx,
    input logic [IDX_WIDTH-1:0] n
  );
    return (idx >= n) ? 32'd0 : idx;
  endfunction

  // Advance the index by one head, wrapping after the last slot of the group.
  function automatic logic [IDX_WIDTH-1:0] idx_next(
    input logic [IDX_WIDTH-1:0] idx_eff,
    input logic [IDX_WIDTH-1:0] n
  );
    return (idx_eff == (n - 32'd1)) ? 32'd0 : (idx_eff + 32'd1);
  endfunction

endpackage

// File: rtl/osnt_packet_sampler_if.sv
// osnt_packet_sampler_if
//   AXI4-Stream bundle used on both sides of the sampler.
//   master: drives tdata/tkeep/tuser/tvalid/tlast, receives tready.
//   slave : receives tdata/tkeep/tuser/tvalid/tlast, drives tready.
interface osnt_packet_sampler_if #(
  parameter int DW = 1024,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, output tkeep, output tuser, output tvalid,
                  output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tuser, input tvalid,
                  input tlast, output tready);
endinterface

// File: rtl/osnt_axis_out_reg.sv
// osnt_axis_out_reg
//   One-deep AXI4-Stream register slice. A beat presented with in_valid
//   while in_ready is high is captured and shown on m_axis the next cycle.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid        load request (caller only raises it on an accepted beat)
//     in_ready        slot free or draining this cycle
//     in_t*           beat payload to capture
//     m_axis          registered output stream (master side)
module osnt_axis_out_reg #(
  parameter int DW = 1024,
  parameter int UW = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_tdata,
  input  logic [DW/8-1:0]      in_tkeep,
  input  logic [UW-1:0]        in_tuser,
  input  logic                 in_tlast,
  osnt_packet_sampler_if.master m_axis
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q,  data_d;
  logic [DW/8-1:0] keep_q,  keep_d;
  logic [UW-1:0]   user_q,  user_d;
  logic            last_q,  last_d;

  // Kept separate from the load logic so ready never depends on in_valid.
  assign in_ready = !valid_q || m_axis.tready;

  // Next-state of the slot: load a new beat, drain, or hold while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    user_d  = user_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_tdata;
      keep_d  = in_tkeep;
      user_d  = in_tuser;
      last_d  = in_tlast;
    end else if (m_axis.tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {DW{1'b0}};
      keep_q  <= {(DW/8){1'b0}};
      user_q  <= {UW{1'b0}};
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tlast  = last_q;

endmodule

// File: rtl/osnt_packet_sampler.sv
// osnt_packet_sampler
//   1-in-N whole-packet sampler on the monitor RX path. Forwards a packet
//   whose sample index is 0 and discards the other N-1 packets whole, with
//   a one-cycle registered output stage. Keeps input/forward/drop counters.
//   Ports:
//     axi_aclk, axi_resetn   clock, asynchronous active-low reset
//     s_axis                 input stream (slave side)
//     m_axis                 sampled output stream (master side)
//     sample_en              1 = sampling active, 0 = forward everything
//     sample_n               ratio N (0 and 1 mean forward everything)
//     stats_clr              one-cycle pulse clearing all counters
//     pkt_in_cnt             packets accepted on s_axis
//     pkt_fwd_cnt            packets completed on m_axis
//     pkt_drop_cnt           packets discarded whole
module osnt_packet_sampler
  import osnt_packet_sampler_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 1024,
  parameter int C_M_AXIS_DATA_WIDTH  = 1024,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  osnt_packet_sampler_if.slave    s_axis,
  osnt_packet_sampler_if.master   m_axis,
  input  logic                    sample_en,
  input  logic [IDX_WIDTH-1:0]    sample_n,
  input  logic                    stats_clr,
  output logic [C_CNT_WIDTH-1:0]  pkt_in_cnt,
  output logic [C_CNT_WIDTH-1:0]  pkt_fwd_cnt,
  output logic [C_CNT_WIDTH-1:0]  pkt_drop_cnt
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ZERO = {C_CNT_WIDTH{1'b0}};
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [C_CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [C_CNT_WIDTH-1:0]  fwd_cnt_q, fwd_cnt_d;
  logic [C_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_tdata_s;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_tkeep_s;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_tuser_s;

  logic                    out_ready_s;
  logic                    s_hs_s;
  logic                    sampling_s;
  logic [IDX_WIDTH-1:0]    idx_eff_s;
  logic                    head_fwd_s;
  logic                    fwd_beat_s;
  logic                    in_end_s;
  logic                    drop_end_s;
  logic                    fwd_end_s;

  assign s_tdata_s = s_axis.tdata;
  assign s_tkeep_s = s_axis.tkeep;
  assign s_tuser_s = s_axis.tuser;

  // DROP sinks beats regardless of the output slot; ready is held low in reset.
  assign s_axis.tready = axi_resetn && ((state_q == ST_DROP) || out_ready_s);
  assign s_hs_s        = s_axis.tvalid && s_axis.tready;

  // The forward/drop decision is combinational on the head beat so a dropped
  // head never reaches the output register.
  assign sampling_s = sample_en && (sample_n > 32'd1);
  assign idx_eff_s  = idx_effective(idx_q, sample_n);
  assign head_fwd_s = !sampling_s || (idx_eff_s == 32'd0);

  assign fwd_beat_s = s_hs_s && ((state_q == ST_PASS) ||
                                 ((state_q == ST_HEAD) && head_fwd_s));
  assign in_end_s   = s_hs_s && s_axis.tlast;
  assign drop_end_s = in_end_s && ((state_q == ST_DROP) ||
                                   ((state_q == ST_HEAD) && !head_fwd_s));
  assign fwd_end_s  = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  osnt_axis_out_reg #(
    .DW (C_M_AXIS_DATA_WIDTH),
    .UW (C_M_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .in_valid (fwd_beat_s),
    .in_ready (out_ready_s),
    .in_tdata (s_tdata_s),
    .in_tkeep (s_tkeep_s),
    .in_tuser (s_tuser_s),
    .in_tlast (s_axis.tlast),
    .m_axis   (m_axis)
  );

  // FSM next state: a single-beat packet completes in HEAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HEAD: begin
        if (s_hs_s && !s_axis.tlast) begin
          state_d = head_fwd_s ? ST_PASS : ST_DROP;
        end else begin
          state_d = ST_HEAD;
        end
      end
      ST_PASS: begin
        if (in_end_s) begin
          state_d = ST_HEAD;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DROP: begin
        if (in_end_s) begin
          state_d = ST_HEAD;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_HEAD;
    endcase
  end

  // Sample index advances once per accepted head beat; sample_n is only
  // consulted there, so mid-packet ratio changes apply to the next head.
  always_comb begin
    idx_d = idx_q;
    if (s_hs_s && (state_q == ST_HEAD)) begin
      if (sampling_s) begin
        idx_d = idx_next(idx_eff_s, sample_n);
      end else begin
        idx_d = 32'd0;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Statistics: free-running wrap, clear takes priority over any increment.
  always_comb begin
    in_cnt_d   = in_cnt_q;
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (stats_clr) begin
      in_cnt_d   = CNT_ZERO;
      fwd_cnt_d  = CNT_ZERO;
      drop_cnt_d = CNT_ZERO;
    end else begin
      in_cnt_d   = in_end_s   ? (in_cnt_q + CNT_ONE)   : in_cnt_q;
      fwd_cnt_d  = fwd_end_s  ? (fwd_cnt_q + CNT_ONE)  : fwd_cnt_q;
      drop_cnt_d = drop_end_s ? (drop_cnt_q + CNT_ONE) : drop_cnt_q;
    end
  end

  // State, index and counter registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_HEAD;
      idx_q      <= 32'd0;
      in_cnt_q   <= CNT_ZERO;
      fwd_cnt_q  <= CNT_ZERO;
      drop_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_cnt_q   <= in_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_in_cnt   = in_cnt_q;
  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_osnt_packet_sampler.sv
// tb_osnt_packet_sampler
//   Randomized scoreboard bench for osnt_packet_sampler. The driver decides
//   each packet's fate with a modulo-N reference model and queues the beats
//   expected on m_axis; a separate monitor pops and compares them.
module tb_osnt_packet_sampler;
  import osnt_packet_sampler_pkg::*;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          sample_en;
  logic [31:0]   sample_n;
  logic          stats_clr;
  logic [CW-1:0] pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt;

  osnt_packet_sampler_if #(.DW(DW), .UW(UW)) s_if ();
  osnt_packet_sampler_if #(.DW(DW), .UW(UW)) m_if ();

  osnt_packet_sampler #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .C_CNT_WIDTH          (CW)
  ) dut (
    .axi_aclk     (clk),
    .axi_resetn   (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .sample_en    (sample_en),
    .sample_n     (sample_n),
    .stats_clr    (stats_clr),
    .pkt_in_cnt   (pkt_in_cnt),
    .pkt_fwd_cnt  (pkt_fwd_cnt),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int unsigned midx = 0;
  int    exp_in = 0, exp_fwd = 0, exp_drop = 0;
  int    stalls = 0;
  bit    rand_ready = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: every N-th head (counting from a fresh group) is kept.
  function automatic bit model_head(input bit en, input int unsigned n);
    bit fwd;
    if (!en || n <= 1) begin
      midx = 0;
      fwd  = 1'b1;
    end else begin
      if (midx >= n) midx = 0;
      fwd  = (midx == 0);
      midx = (midx + 1) % n;
    end
    return fwd;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rand_user(input int nbytes);
    logic [UW-1:0] u;
    for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
    u[TUSER_LEN_MSB:TUSER_LEN_LSB] = 16'(nbytes);
    return u;
  endfunction

  // Random downstream back-pressure, or always-ready.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every m_axis handshake, check stall stability.
  initial begin
    beat_t         b;
    logic          pv, pr;
    beat_t         pb;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall_valid", m_if.tvalid, 1'b1);
          chk("stall_data", m_if.tdata, pb.data);
          chk("stall_user", m_if.tuser, pb.user);
          chk("stall_keep_last", {m_if.tkeep, m_if.tlast}, {pb.keep, pb.last});
        end
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", m_if.tvalid, 1'b0);
          end else begin
            b = exp_q.pop_front();
            chk("out_data", m_if.tdata, b.data);
            chk("out_keep", m_if.tkeep, b.keep);
            chk("out_user", m_if.tuser, b.user);
            chk("out_last", m_if.tlast, b.last);
            if (b.last) exp_fwd++;
          end
        end
        pv = m_if.tvalid;
        pr = m_if.tready;
        pb.data = m_if.tdata;
        pb.keep = m_if.tkeep;
        pb.user = m_if.tuser;
        pb.last = m_if.tlast;
      end
    end
  end

  // Drive one packet; optionally change N after the head or clear stats on tlast.
  task automatic send_pkt(input int nbeats, input int gap_max, input int new_n, input bit clr_on_last);
    bit            fwd, hs;
    beat_t         b;
    logic [UW-1:0] user;
    int            w;
    fwd  = model_head(sample_en, sample_n);
    user = rand_user(nbeats * KW);
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      b.data = rand_data();
      b.last = (i == nbeats - 1);
      b.keep = b.last ? ({KW{1'b1}} >> (KW - $urandom_range(1, KW))) : {KW{1'b1}};
      b.user = user;
      s_if.tdata  = b.data;
      s_if.tkeep  = b.keep;
      s_if.tuser  = b.user;
      s_if.tlast  = b.last;
      s_if.tvalid = 1'b1;
      if (clr_on_last && b.last) stats_clr = 1'b1;
      w = 0;
      forever begin
        @(negedge clk);
        if (!fwd && i > 0) chk("drop_tready", s_if.tready, 1'b1);
        hs = s_if.tready;
        if (hs) begin
          if (fwd) exp_q.push_back(b);
          if (b.last) begin
            exp_in++;
            if (!fwd) exp_drop++;
            if (clr_on_last) begin
              exp_in = 0; exp_drop = 0; exp_fwd = 0;
            end
          end
        end
        @(posedge clk);
        #1;
        if (hs) break;
        stalls++;
        w++;
        if (w > 1000) begin
          chk("s_handshake_timeout", 1'b1, 1'b0);
          break;
        end
      end
      stats_clr = 1'b0;
      if (i == 0 && new_n != 0) sample_n = 32'(new_n);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_timeout", 1'(w >= 5000), 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    exp_in = 0; exp_fwd = 0; exp_drop = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_in"}, pkt_in_cnt, exp_in);
    chk({tag, "_fwd"}, pkt_fwd_cnt, exp_fwd);
    chk({tag, "_drop"}, pkt_drop_cnt, exp_drop);
  endtask

  task automatic reset_idx();
    sample_en = 1'b0;
    send_pkt(1, 0, 0, 1'b0);
    drain();
    clear_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b0;
    sample_n  = 32'd0;
    stats_clr = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tuser = '0;
    s_if.tlast = 1'b0;
    #22;
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, '0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    chk("rst_cnts", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: sampling off, everything forwarded
    for (int p = 0; p < 10; p++) send_pkt(3, 1, 0, 1'b0);
    drain();
    check_counts("t1");
    chk("t1_in_const", pkt_in_cnt, 32'd10);
    chk("t1_fwd_const", pkt_fwd_cnt, 32'd10);

    // 2: N=4 -> packets 0,4,8 kept
    clear_stats();
    sample_en = 1'b1;
    sample_n  = 32'd4;
    for (int p = 0; p < 12; p++) send_pkt(3, 0, 0, 1'b0);
    drain();
    check_counts("t2");
    chk("t2_const", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, {32'd12, 32'd3, 32'd9});

    // 3: N=3 with random back-pressure and random packet lengths
    clear_stats();
    sample_n   = 32'd3;
    rand_ready = 1'b1;
    for (int p = 0; p < 18; p++) send_pkt($urandom_range(1, 4), 2, 0, 1'b0);
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    check_counts("t3");

    // 4: N=2 single-beat packets back-to-back
    reset_idx();
    sample_en = 1'b1;
    sample_n  = 32'd2;
    stalls    = 0;
    for (int p = 0; p < 20; p++) send_pkt(1, 0, 0, 1'b0);
    chk("t4_stalls", stalls, 0);
    drain();
    check_counts("t4");
    chk("t4_const", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, {32'd20, 32'd10, 32'd10});

    // 5: N changes 4->2 in the middle of the packet seen with idx=3
    reset_idx();
    sample_en = 1'b1;
    sample_n  = 32'd4;
    send_pkt(2, 0, 0, 1'b0);
    send_pkt(2, 0, 0, 1'b0);
    send_pkt(3, 0, 2, 1'b0);
    for (int p = 0; p < 3; p++) send_pkt(2, 0, 0, 1'b0);
    drain();
    check_counts("t5");
    chk("t5_const", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, {32'd6, 32'd3, 32'd3});

    // 6a: stats_clr coincident with the input tlast handshake
    sample_en = 1'b0;
    clear_stats();
    send_pkt(2, 0, 0, 1'b1);
    drain();
    check_counts("t6a");
    chk("t6a_const", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, {32'd0, 32'd1, 32'd0});

    // 6b: reset asserted in the middle of a forwarded packet
    for (int i = 0; i < 2; i++) begin
      s_if.tdata  = rand_data();
      s_if.tkeep  = {KW{1'b1}};
      s_if.tuser  = rand_user(4 * KW);
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b1;
      @(negedge clk);
      chk("t6b_s_tready", s_if.tready, 1'b1);
      exp_q.push_back('{s_if.tdata, s_if.tkeep, s_if.tuser, 1'b0});
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    chk("t6b_pre_tvalid", m_if.tvalid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6b_rst_tvalid", m_if.tvalid, 1'b0);
    chk("t6b_rst_tready", s_if.tready, 1'b0);
    chk("t6b_rst_cnts", {pkt_in_cnt, pkt_fwd_cnt, pkt_drop_cnt}, '0);
    exp_q.delete();
    midx = 0;
    exp_in = 0; exp_fwd = 0; exp_drop = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b1;
    sample_n  = 32'd3;
    for (int p = 0; p < 4; p++) send_pkt(2, 0, 0, 1'b0);
    drain();
    check_counts("t6b_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
